// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for the single-bus multicycle MIPS-subset datapath. It steps
//   each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle
//   strobes for the IR, PC, A/B, ALUOut, the register file and the memory port.
//   Memory accesses use a req/ready handshake. An illegal opcode/funct, or a
//   memory access that waits too long, parks the FSM in TRAP until reset.
//
//   Supported: lw, sw, j, jal, beq, bne, xori, addi, and R-type add, sub, slt, jr.
//
// Optional build macro: MULTICYCLE_CTRL_PERF_EN adds the cycle and instruction
// counters (cyc_cnt, instr_cnt).
//
// Parameters
//   TIMEOUT_CYC  most consecutive mem_req-without-mem_ready cycles allowed
//                before a trap; 0 disables the timeout
//   CNT_W        width of the performance counters
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   opcode      IR[31:26]
//   funct       IR[5:0]
//   zero        ALU zero flag, valid in EXEC
//   mem_ready   memory completes the current access this cycle
//   state       FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   mem_req     memory access request
//   mem_wr      the request is a write (sw)
//   ir_wr       load IR from memory read data
//   pc_wr       load PC from the pc_src mux
//   pc_src      0=PC+4 1=branch target 2=jump target 3=rs
//   ab_wr       latch register-file outputs into A/B
//   alu_wr      latch the ALU result into ALUOut
//   reg_wr      register-file write enable
//   instr_done  one-cycle pulse on the last cycle of each instruction
//   trap        high while in TRAP
//   trap_cause  0=none 1=illegal instruction 2=memory timeout; held until reset
//   cyc_cnt     (perf build) non-reset cycles spent outside TRAP
//   instr_cnt   (perf build) completed instructions
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             ab_wr,
  output logic             alu_wr,
  output logic             reg_wr,
  output logic             instr_done,
  output logic             trap,
`ifdef MULTICYCLE_CTRL_PERF_EN
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`else
  output logic [1:0]       trap_cause
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] PCS_SEQ    = 2'd0;
  localparam logic [1:0] PCS_BRANCH = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);
  localparam int unsigned TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TMO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  state_t        state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic [TW-1:0] tmo_q;

  // Ungated strobes; reset masks them below.
  logic       req_c, wr_c, ir_c, pc_c, ab_c, alu_c, rw_c, done_c;
  logic [1:0] pcs_c;

  // Instruction decode
  logic is_r, is_add, is_sub, is_slt, is_jr;
  logic is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw;
  logic legal;
  logic tmo_last;

  always_comb begin
    is_r    = (opcode == OP_RTYPE);
    is_add  = is_r && (funct == FN_ADD);
    is_sub  = is_r && (funct == FN_SUB);
    is_slt  = is_r && (funct == FN_SLT);
    is_jr   = is_r && (funct == FN_JR);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_addi = (opcode == OP_ADDI);
    is_xori = (opcode == OP_XORI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    legal   = is_add | is_sub | is_slt | is_jr | is_j | is_jal | is_beq |
              is_bne | is_addi | is_xori | is_lw | is_sw;
    // This wait cycle is the TIMEOUT_CYC-th one; used only when mem_ready=0,
    // so a ready arriving on the limit cycle still completes the access.
    tmo_last = TMO_EN && (tmo_q == TW'(TMO_LAST));
  end

  // Next-state and strobe logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    req_c   = 1'b0;
    wr_c    = 1'b0;
    ir_c    = 1'b0;
    pc_c    = 1'b0;
    pcs_c   = PCS_SEQ;
    ab_c    = 1'b0;
    alu_c   = 1'b0;
    rw_c    = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_c    = 1'b1;
          pc_c    = 1'b1;
          pcs_c   = PCS_SEQ;
          state_d = S_DECODE;
        end else if (tmo_last) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        ab_c = 1'b1;
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_j) begin
          pc_c    = 1'b1;
          pcs_c   = PCS_JUMP;
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_c    = 1'b1;
          pcs_c   = PCS_RS;
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_c = 1'b1;
        if (is_beq || is_bne) begin
          pc_c    = (is_beq & zero) | (is_bne & ~zero);
          pcs_c   = PCS_BRANCH;
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        req_c = 1'b1;
        wr_c  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_last) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        rw_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
        if (is_jal) begin
          pc_c  = 1'b1;
          pcs_c = PCS_JUMP;
        end
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Reset suppresses every write so an interrupted instruction has no effect.
  always_comb begin
    mem_req    = req_c  & ~reset;
    mem_wr     = wr_c   & ~reset;
    ir_wr      = ir_c   & ~reset;
    pc_wr      = pc_c   & ~reset;
    ab_wr      = ab_c   & ~reset;
    alu_wr     = alu_c  & ~reset;
    reg_wr     = rw_c   & ~reset;
    instr_done = done_c & ~reset;
    pc_src     = pcs_c;
    state      = state_q;
    trap       = (state_q == S_TRAP);
    trap_cause = cause_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (TMO_EN && req_c && !mem_ready && (state_d == state_q)) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) begin
        cyc_cnt_q <= cyc_cnt_q + 1'b1;
      end
      if (done_c) begin
        instr_cnt_q <= instr_cnt_q + 1'b1;
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. The stimulus process drives one cycle at a
// time and queues the hand-computed expected output vector for that cycle;
// the monitor pops and compares it on the falling edge.
// Expected vector layout:
//   [15:13] state [12] mem_req [11] mem_wr [10] ir_wr [9] pc_wr [8:7] pc_src
//   [6] ab_wr [5] alu_wr [4] reg_wr [3] instr_done [2] trap [1:0] trap_cause
// pc_src is only compared when pc_wr is expected high.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state;
  logic       mem_req, mem_wr, ir_wr, pc_wr, ab_wr, alu_wr, reg_wr, instr_done, trap;
  logic [1:0] pc_src, trap_cause;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.TIMEOUT_CYC(4), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .state      (state),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .ab_wr      (ab_wr),
    .alu_wr     (alu_wr),
    .reg_wr     (reg_wr),
    .instr_done (instr_done),
    .trap       (trap),
`ifdef MULTICYCLE_CTRL_PERF_EN
    .trap_cause (trap_cause),
    .cyc_cnt    (cyc_cnt),
    .instr_cnt  (instr_cnt)
`else
    .trap_cause (trap_cause)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] ex;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  //                       st    rq  wr  ir  pc  src   ab  alu rw  dn  tr  cause
  localparam logic [15:0] X_RST0  = {3'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_FHIT  = {3'd0,1'b1,1'b0,1'b1,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_FWAIT = {3'd0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_DEC   = {3'd1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_DEC_J = {3'd1,1'b0,1'b0,1'b0,1'b1,2'd2,1'b1,1'b0,1'b0,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_DEC_JR= {3'd1,1'b0,1'b0,1'b0,1'b1,2'd3,1'b1,1'b0,1'b0,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_EXE   = {3'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_EXE_BT= {3'd2,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_EXE_BN= {3'd2,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_MEM_R = {3'd3,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_MEM_W = {3'd3,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_MEM_RS= {3'd3,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
  localparam logic [15:0] X_WB    = {3'd4,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_WB_JAL= {3'd4,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0};
  localparam logic [15:0] X_TRAP1 = {3'd7,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1};
  localparam logic [15:0] X_TRAP2 = {3'd7,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2};

  // One clock cycle of stimulus plus the expected outputs for that cycle.
  task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic rst,
                     input logic [15:0] ex);
    @(posedge clk);
    #1;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
    reset     = rst;
    sb.push_back('{nm, ex});
  endtask

  // Four-cycle ALU-class instruction with no wait states.
  task automatic alu4(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cyc({nm, "_fetch"}, op, fn, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc({nm, "_dec"},   op, fn, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc({nm, "_exec"},  op, fn, 1'b0, 1'b1, 1'b0, X_EXE);
    cyc({nm, "_wb"},    op, fn, 1'b0, 1'b1, 1'b0, X_WB);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        it;
      logic [15:0] act, ex;
      it  = sb.pop_front();
      act = {state, mem_req, mem_wr, ir_wr, pc_wr, pc_src, ab_wr, alu_wr,
             reg_wr, instr_done, trap, trap_cause};
      ex  = it.ex;
      if (ex[9] == 1'b0) begin
        act[8:7] = 2'b00;
        ex[8:7]  = 2'b00;
      end
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.nm, act, ex);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: strobes low, state FETCH
    cyc("reset",  6'h00, 6'h00, 1'b0, 1'b1, 1'b1, X_RST0);

    // R-type and immediate ALU instructions
    alu4("add",  6'h00, 6'h20);
    alu4("sub",  6'h00, 6'h22);
    alu4("slt",  6'h00, 6'h2A);
    alu4("addi", 6'h08, 6'h00);
    alu4("xori", 6'h0E, 6'h3F);

    // lw with 3 wait cycles in MEM: 8 cycles total
    cyc("lw_fetch", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("lw_dec",   6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("lw_exec",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_EXE);
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_MEM_R);
    cyc("lw_mem_rdy", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_MEM_R);
    cyc("lw_wb",      6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_WB);

    // sw, no waits
    cyc("sw_fetch", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("sw_dec",   6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("sw_exec",  6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, X_EXE);
    cyc("sw_mem",   6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, X_MEM_W);

    // beq zero=1 taken; bne zero=1 not taken; bne zero=0 taken
    cyc("beq_fetch", 6'h04, 6'h00, 1'b1, 1'b1, 1'b0, X_FHIT);
    cyc("beq_dec",   6'h04, 6'h00, 1'b1, 1'b1, 1'b0, X_DEC);
    cyc("beq_exec",  6'h04, 6'h00, 1'b1, 1'b1, 1'b0, X_EXE_BT);
    cyc("bne_fetch", 6'h05, 6'h00, 1'b1, 1'b1, 1'b0, X_FHIT);
    cyc("bne_dec",   6'h05, 6'h00, 1'b1, 1'b1, 1'b0, X_DEC);
    cyc("bne_exec",  6'h05, 6'h00, 1'b1, 1'b1, 1'b0, X_EXE_BN);
    cyc("bne0_fetch",6'h05, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("bne0_dec",  6'h05, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("bne0_exec", 6'h05, 6'h00, 1'b0, 1'b1, 1'b0, X_EXE_BT);

    // j with two fetch wait states, jal, jr
    cyc("j_fwait",   6'h02, 6'h00, 1'b0, 1'b0, 1'b0, X_FWAIT);
    cyc("j_fwait",   6'h02, 6'h00, 1'b0, 1'b0, 1'b0, X_FWAIT);
    cyc("j_fetch",   6'h02, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("j_dec",     6'h02, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC_J);
    cyc("jal_fetch", 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("jal_dec",   6'h03, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("jal_wb",    6'h03, 6'h00, 1'b0, 1'b1, 1'b0, X_WB_JAL);
    cyc("jr_fetch",  6'h00, 6'h08, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("jr_dec",    6'h00, 6'h08, 1'b0, 1'b1, 1'b0, X_DEC_JR);

    // Reset in the middle of a MEM wait aborts with no strobes
    cyc("lwr_fetch", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("lwr_dec",   6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("lwr_exec",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_EXE);
    cyc("lwr_wait",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_MEM_R);
    cyc("lwr_reset", 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, X_MEM_RS);
    cyc("lwr_after", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);

    // Illegal opcode 0x3F: trap held for 10 cycles, then reset clears it
    cyc("ill_dec",   6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    for (int i = 0; i < 10; i++)
      cyc("ill_trap", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, X_TRAP1);
    cyc("ill_reset", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, X_TRAP1);
    cyc("ill_after", 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, X_FHIT);

    // R-type with unknown funct
    cyc("fn_dec",    6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("fn_trap",   6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, X_TRAP1);
    cyc("fn_trap",   6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, X_TRAP1);
    cyc("fn_reset",  6'h00, 6'h3F, 1'b0, 1'b0, 1'b1, X_TRAP1);

    // Fetch timeout: 4 wait cycles then TRAP with cause 2
    for (int i = 0; i < 4; i++)
      cyc("to_fwait", 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, X_FWAIT);
    cyc("to_trap",   6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_TRAP2);
    cyc("to_trap",   6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_TRAP2);
    cyc("to_reset",  6'h00, 6'h20, 1'b0, 1'b0, 1'b1, X_TRAP2);

    // Ready on the limit cycle wins: proceeds to DECODE
    for (int i = 0; i < 3; i++)
      cyc("lim_fwait", 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, X_FWAIT);
    cyc("lim_fetch", 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("lim_dec",   6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("lim_exec",  6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_EXE);
    cyc("lim_wb",    6'h00, 6'h20, 1'b0, 1'b1, 1'b0, X_WB);

    // MEM timeout on lw
    cyc("mto_fetch", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_FHIT);
    cyc("mto_dec",   6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_DEC);
    cyc("mto_exec",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_EXE);
    for (int i = 0; i < 4; i++)
      cyc("mto_wait", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_MEM_R);
    cyc("mto_trap",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0, X_TRAP2);
    cyc("mto_reset", 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, X_TRAP2);

    // Clean instruction after recovery
    alu4("add2", 6'h00, 6'h20);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
